relu_maxpool_2x2: RTL and testbench
===================================

// Module: relu_maxpool_2x2
// PURPOSE
//   Streaming 2x2/stride-2 max-pool stage, with optional ReLU, directly downstream of the 5x5 conv engine.
//   Consumes the conv's raster-order signed result stream, one word per valid beat.
//   Emits one pooled word per 2x2 window as soon as the window's last pixel arrives.
//   Feeds the next layer's input line buffer.
// PARAMETERS
//   word_length        8   pixel width of the original image
//   double_word_length 16  width of conv results and of pooled outputs
//   kernel_size        5   conv kernel size; sets feature-map width
//   image_size         36  conv input image side
//   FMAP_W (localparam) image_size-kernel_size+1 (=32). Conv output side.
//   POOL_W (localparam) FMAP_W/2 (=16). Pooled output side; floor division.
// PORTS
//   clk        in   1   single clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   data_in valid this cycle; gaps allowed, no backpressure
//   data_in    in   16  signed conv result, raster order, row 0 col 0 first
//   out_valid  out  1   data_out valid; one-cycle pulse per pooled word
//   data_out   out  16  signed pooled word, raster order over POOL_W x POOL_W
//   frame_done out  1   pulses with the last pooled word of a frame
// BEHAVIOUR
//   - Reset (async, rst_n=0): out_valid=0, frame_done=0, data_out=0, col=0, row=0, hold reg=0.
//     Row buffer contents are not cleared; each even row overwrites them before use.
//   - Beats are counted only when in_valid=1. col runs 0..FMAP_W-1 and wraps to 0 with row+1.
//     row runs 0..FMAP_W-1 and wraps to 0 at end of frame.
//   - Pre-op v = RELU_EN ? (data_in<0 ? 0 : data_in) : data_in. All compares are signed 16-bit.
//   - Even col: hold <= v.
//   - Odd col: p = max(hold, v).
//     Even row: rowbuf[col>>1] <= p.
//     Odd row: data_out <= max(rowbuf[col>>1], p); out_valid <= 1.
//   - Latency: out_valid asserts the cycle after the in_valid beat carrying window pixel (2r+1, 2c+1).
//   - If FMAP_W is odd, the last column and last row feed no window. They are counted but discarded.
//   - frame_done=1 in the same cycle as the out_valid for pooled (POOL_W-1, POOL_W-1).
//   - A new frame may follow with zero idle cycles.
//   - Reset mid-frame: the partial frame is abandoned with no output. The next beat after release is (0,0).
//   - No overflow is possible: max() preserves width.
// CONFIGURATION
//   RELU_EN defined: negative inputs are clamped to 0 before pooling, so outputs are always >=0.
//   RELU_EN undefined: pure signed max-pool; negative outputs pass through unchanged.
// STRUCTURE
//   - Package conv_pkg:
//     - result_t typedef (signed [15:0])
//     - function fmap_w(image_size, kernel_size)
//     - function smax(a, b)
//   - Sub-module pool_row_buffer: POOL_W x 16 single-port register array.
//     Write in even rows, read in odd rows, at address col>>1.
//   - Top holds the col/row counters, hold reg, compare logic and output regs.
// TESTING (defaults, FMAP_W=32, 1024 beats -> 256 outputs per frame)
//   1. Ramp data_in = row*32+col, continuous valid.
//      -> outputs (2r+1)*32+2c+1. First 33, second 35, last 1023.
//      -> exactly 256 out_valid; frame_done only on the 1023 output.
//   2. All inputs -5 (16'hFFFB).
//      -> RELU_EN defined: 256 outputs of 0.
//      -> undefined: 256 outputs of 16'hFFFB.
//   3. Ramp of test 1 with in_valid toggling 1,0,1,0.
//      -> same 256 values as test 1; each out_valid 1 cycle after its (odd,odd) beat.
//   4. Single spike 100 at (0,0), rest 0; repeat with the spike at (1,1) and at (31,31).
//      -> pooled(0,0)=100, pooled(0,0)=100, pooled(15,15)=100 respectively; all other outputs 0.
//   5. rst_n low for 2 cycles after 500 ramp beats, then a full ramp frame.
//      -> no output during reset; then exactly test-1 output set and one frame_done.
//   6. Two ramp frames back-to-back with no gap.
//      -> 512 outputs, frame_done at outputs 256 and 512, second frame identical to the first.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and helpers for the conv / pooling pipeline.
package conv_pkg;

  typedef logic signed [15:0] result_t;

  function automatic int fmap_w(input int image_size, input int kernel_size);
    return image_size - kernel_size + 1;
  endfunction

  function automatic result_t smax(input result_t a, input result_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_row_buffer.sv
// One pooled row of horizontal pair maxima: written on even fmap rows, read on odd rows.
module pool_row_buffer
  import conv_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);

  // Contents are not reset; every even row rewrites each entry before the odd row reads it.
  result_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= result_t'(wdata);
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/relu_maxpool_2x2.sv
// Streaming 2x2/stride-2 max-pool with optional ReLU (enabled by defining RELU_EN).
// Interface: in_valid qualifies data_in (no backpressure); out_valid is a one-cycle pulse per pooled word.
module relu_maxpool_2x2
  import conv_pkg::*;
#(
  parameter int word_length        = 8,
  parameter int double_word_length = 16,
  parameter int kernel_size        = 5,
  parameter int image_size         = 36
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] data_in,
  output logic        out_valid,
  output logic [15:0] data_out,
  output logic        frame_done
);

  localparam int FMAP_W = fmap_w(image_size, kernel_size);
  localparam int POOL_W = FMAP_W / 2;
  localparam int CW     = (FMAP_W > 2) ? $clog2(FMAP_W) : 2;
  localparam int AW     = CW - 1;

  // The datapath is fixed to the 16-bit result type; other widths leave an empty marker block.
  if ((double_word_length != $bits(result_t)) || (word_length > double_word_length)) begin : g_unsupported_width
  end

  logic [CW-1:0] col;
  logic [CW-1:0] row;
  result_t       hold;
  result_t       din_s;
  result_t       v;
  result_t       pair_max;
  result_t       win_max;
  logic [15:0]   rb_rdata;
  logic          rb_we;
  logic [AW-1:0] rb_addr;
  logic          col_last;
  logic          row_last;
  logic          win_last;

  assign din_s = result_t'(data_in);

`ifdef RELU_EN
  assign v = din_s[15] ? result_t'(0) : din_s;
`else
  assign v = din_s;
`endif

  assign pair_max = smax(hold, v);
  assign win_max  = smax(result_t'(rb_rdata), pair_max);

  assign col_last = (col == CW'(FMAP_W - 1));
  assign row_last = (row == CW'(FMAP_W - 1));
  assign win_last = (row == CW'(2 * POOL_W - 1)) && (col == CW'(2 * POOL_W - 1));

  assign rb_addr = col[CW-1:1];
  assign rb_we   = in_valid && col[0] && !row[0];

  pool_row_buffer #(
    .DEPTH  (POOL_W),
    .ADDR_W (AW)
  ) u_row_buffer (
    .clk   (clk),
    .we    (rb_we),
    .addr  (rb_addr),
    .wdata (pair_max),
    .rdata (rb_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (in_valid) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + CW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
    end else if (in_valid && !col[0]) begin
      hold <= v;
    end
  end

  // With an odd FMAP_W the trailing even column/row never reach an odd-odd beat, so they drop out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      data_out   <= '0;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (in_valid && col[0] && row[0]) begin
        data_out   <= win_max;
        out_valid  <= 1'b1;
        frame_done <= win_last;
      end
    end
  end

endmodule

// File: tb/tb_relu_maxpool_2x2.sv
// Self-checking bench for relu_maxpool_2x2: frame-level reference model plus cycle-exact output checks.
module tb_relu_maxpool_2x2;

  localparam int FW = 32;
  localparam int PW = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] data_in;
  logic        out_valid;
  logic [15:0] data_out;
  logic        frame_done;

  int tests = 0;
  int fails = 0;
  int out_cnt = 0;
  int done_cnt = 0;
  logic        have_first;
  logic [15:0] first_out;
  logic [15:0] last_out;

  logic signed [15:0] pix [FW][FW];
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  relu_maxpool_2x2 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .data_in    (data_in),
    .out_valid  (out_valid),
    .data_out   (data_out),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: each pooled word is the max of its four (optionally rectified) pixels.
  task automatic build_expect();
    for (int pr = 0; pr < PW; pr++) begin
      for (int pc = 0; pc < PW; pc++) begin
        int m;
        m = -100000;
        for (int dr = 0; dr < 2; dr++) begin
          for (int dc = 0; dc < 2; dc++) begin
            int a;
            a = int'(pix[2*pr+dr][2*pc+dc]);
`ifdef RELU_EN
            if (a < 0) a = 0;
`endif
            if (a > m) m = a;
          end
        end
        exp_q.push_back(16'(m));
      end
    end
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < FW; r++)
      for (int c = 0; c < FW; c++) pix[r][c] = 16'(r * FW + c);
  endtask

  task automatic fill_const(input logic [15:0] val);
    for (int r = 0; r < FW; r++)
      for (int c = 0; c < FW; c++) pix[r][c] = val;
  endtask

  task automatic fill_spike(input int sr, input int sc);
    fill_const(16'h0000);
    pix[sr][sc] = 16'sd100;
  endtask

  task automatic fill_random();
    for (int r = 0; r < FW; r++)
      for (int c = 0; c < FW; c++) pix[r][c] = 16'($urandom);
  endtask

  task automatic sample_cycle(input logic exp_v, input logic exp_d);
    @(posedge clk);
    #1;
    check("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
    check("frame_done", {31'd0, frame_done}, {31'd0, exp_d});
    if (out_valid) begin
      out_cnt++;
      last_out = data_out;
      if (!have_first) begin
        have_first = 1'b1;
        first_out  = data_out;
      end
    end
    if (frame_done) done_cnt++;
    if (exp_v) begin
      if (exp_q.size() == 0) check("exp_q_empty", 32'd1, 32'd0);
      else check("data_out", {16'd0, data_out}, {16'd0, exp_q.pop_front()});
    end
  endtask

  task automatic drive_beat(input int r, input int c);
    @(negedge clk);
    in_valid = 1'b1;
    data_in  = pix[r][c];
    sample_cycle((r % 2 == 1) && (c % 2 == 1), (r == FW - 1) && (c == FW - 1));
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0;
    data_in  = 16'($urandom);
    sample_cycle(1'b0, 1'b0);
  endtask

  // gap_mode: 0 continuous, 1 alternate valid/idle, 2 random idle gaps
  task automatic drive_frame(input int gap_mode, input int n_beats);
    for (int i = 0; i < n_beats; i++) begin
      drive_beat(i / FW, i % FW);
      if (gap_mode == 1) idle_cycle();
      if (gap_mode == 2) repeat ($urandom_range(0, 2)) idle_cycle();
    end
  endtask

  task automatic start_counts();
    out_cnt    = 0;
    done_cnt   = 0;
    have_first = 1'b0;
  endtask

  task automatic frame_check(input int n_out, input int n_done);
    check("out_count", 32'(out_cnt), 32'(n_out));
    check("done_count", 32'(done_cnt), 32'(n_done));
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    data_in  = 16'h0000;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_data_out", {16'd0, data_out}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Ramp, continuous valid
    fill_ramp(); build_expect(); start_counts();
    drive_frame(0, FW * FW);
    frame_check(PW * PW, 1);
    check("ramp_first", {16'd0, first_out}, 32'd33);
    check("ramp_last", {16'd0, last_out}, 32'd1023);

    // Constant -5
    fill_const(16'hFFFB); build_expect(); start_counts();
    drive_frame(0, FW * FW);
    frame_check(PW * PW, 1);
`ifdef RELU_EN
    check("neg_const", {16'd0, last_out}, 32'h0000);
`else
    check("neg_const", {16'd0, last_out}, 32'hFFFB);
`endif

    // Ramp with toggling valid
    fill_ramp(); build_expect(); start_counts();
    drive_frame(1, FW * FW);
    frame_check(PW * PW, 1);
    check("toggle_first", {16'd0, first_out}, 32'd33);

    // Spikes at window corners
    fill_spike(0, 0); build_expect(); start_counts();
    drive_frame(0, FW * FW);
    frame_check(PW * PW, 1);
    check("spike00_first", {16'd0, first_out}, 32'd100);
    fill_spike(1, 1); build_expect(); start_counts();
    drive_frame(0, FW * FW);
    frame_check(PW * PW, 1);
    check("spike11_first", {16'd0, first_out}, 32'd100);
    fill_spike(31, 31); build_expect(); start_counts();
    drive_frame(0, FW * FW);
    frame_check(PW * PW, 1);
    check("spike3131_last", {16'd0, last_out}, 32'd100);

    // Reset mid-frame after 500 beats
    fill_ramp(); build_expect(); start_counts();
    drive_frame(0, 500);
    check("partial_out_count", 32'(out_cnt), 32'd122);
    check("partial_done_count", 32'(done_cnt), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    data_in  = 16'h7FFF;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_frame_done", {31'd0, frame_done}, 32'd0);
      check("midrst_data_out", {16'd0, data_out}, 32'd0);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    build_expect(); start_counts();
    drive_frame(0, FW * FW);
    frame_check(PW * PW, 1);
    check("after_rst_first", {16'd0, first_out}, 32'd33);

    // Two ramp frames back-to-back
    fill_ramp(); build_expect(); build_expect(); start_counts();
    drive_frame(0, FW * FW);
    drive_frame(0, FW * FW);
    frame_check(2 * PW * PW, 2);

    // Random data with random gaps, then back-to-back random frame
    fill_random(); build_expect(); start_counts();
    drive_frame(2, FW * FW);
    frame_check(PW * PW, 1);
    fill_random(); build_expect(); start_counts();
    drive_frame(0, FW * FW);
    frame_check(PW * PW, 1);

    repeat (3) idle_cycle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
